xil_dp_arbiter: RTL and testbench
=================================

# xil_dp_arbiter

Round-robin arbiter that shares one simple dual-port, single-clock block RAM (one write port, one read port) among NUM_REQ requesters. Write and read ports are arbitrated independently, each with its own rotating priority. Read data is returned through a latency-matched tag pipeline that reports which requester owns each returned word. The block sits between the on-chip masters (DMA, CSR bridge, accelerator front ends) and the BRAM primitive wrapper, and drives that wrapper's ports directly.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- RAM_WIDTH, 32: data width.
- RAM_DEPTH, 2048: entries; ADDR_W = clog2(RAM_DEPTH).
- RD_LATENCY, 1: RAM read latency. 1 = no output register; 2 = output register.

Ports (one clock; reset is synchronous and active-high):
- clka  in  1  clock for all logic and the RAM.
- rstb  in  1  synchronous active-high reset.
- wr_req  in  NUM_REQ  per-requester write request.
- wr_addr  in  NUM_REQ*ADDR_W  packed write addresses; requester i occupies slice i.
- wr_data  in  NUM_REQ*RAM_WIDTH  packed write data.
- wr_gnt  out  NUM_REQ  one-hot write grant; the write completes on the clock edge where the grant is high.
- rd_req  in  NUM_REQ  per-requester read request.
- rd_addr  in  NUM_REQ*ADDR_W  packed read addresses.
- rd_gnt  out  NUM_REQ  one-hot read grant.
- rd_valid  out  NUM_REQ  one-hot; high for one cycle when rd_data belongs to that requester.
- rd_data  out  RAM_WIDTH  shared read data.
- ram_addra, ram_dina, ram_wea  out  ADDR_W / RAM_WIDTH / 1  RAM write port.
- ram_addrb, ram_enb  out  ADDR_W / 1  RAM read port.
- ram_regceb, ram_rstb  out  1 / 1  RAM output-register enable and reset.
- ram_doutb  in  RAM_WIDTH  RAM read data.

## Operation
- Each port has its own arbiter. A grant is combinational from the request and a registered priority pointer. The lowest index at or after the pointer wins, with wrap-around.
- After a grant to requester i, that port's pointer becomes (i+1) mod NUM_REQ. With no grant, the pointer holds.
- Requests are level-sensitive. A requester holds its request, address and data until granted. Deasserting the request without a grant is legal and has no side effects.
- Write grant to requester i: ram_wea=1, ram_addra and ram_dina taken from slice i. Otherwise ram_wea=0 and addra/dina=0.
- Read grant to requester i: ram_enb=1, ram_addrb taken from slice i. Otherwise ram_enb=0 and addrb=0.
- Tag pipeline: RD_LATENCY stages of {valid, one-hot id}.
  - rd_valid is the last stage's id, qualified by its valid bit.
  - rd_data = ram_doutb; it is 0 when no stage-final valid.
- RD_LATENCY=2: ram_regceb = stage-1 valid. RD_LATENCY=1: ram_regceb = 0.
- ram_rstb = rstb.
- A write and a read to the same address in the same cycle return the old data (read-first), unless the bypass in Configuration is compiled in.
- A single requester may hold both a write grant and a read grant in the same cycle.
- Reset:
  - All grants, ram_wea and ram_enb are 0 while rstb is high; requests are ignored.
  - Pointers reset to 0 and tag pipeline valids clear.
  - Reads in flight when reset asserts are dropped: no rd_valid is produced for them.

## Timing
- Grant is in the same cycle as the request (0-cycle arbitration).
- Write data is visible to a read granted one or more cycles later.
- rd_valid and rd_data arrive exactly RD_LATENCY cycles after the cycle of rd_gnt.
- Throughput is one write plus one read per cycle, sustained, with back-to-back grants.
- Fairness: a continuously requesting requester is granted within NUM_REQ cycles on each port.
- Every output is 0 in the first cycle after reset deasserts, until a request arrives.

## Configuration
- Macro XIL_DP_ARB_BYPASS_EN.
- Defined: a same-cycle, same-address write/read collision is detected. A bypass flag and the write data travel down the tag pipeline alongside the tag, and rd_data returns the newly written data. This costs one comparator and RD_LATENCY×RAM_WIDTH flops.
- Undefined: there is no comparator, and read-first data is returned.

## Structure
- Shared package xil_dp_arb_pkg holds:
  - the clog2 function;
  - the ADDR_W derivation;
  - the tag struct {valid, id[NUM_REQ], byp, byp_data}.
- Sub-module xil_rr_arbiter (request vector → one-hot grant, plus pointer register) is instantiated twice, once per port.

## Test plan
- All four requesters assert rd_req continuously from reset → rd_gnt sequence 0001, 0010, 0100, 1000, 0001; each rd_valid follows its grant by RD_LATENCY cycles. Run with RD_LATENCY=1 and RD_LATENCY=2.
- Requester 2 writes 0xDEADBEEF to address 5; requester 0 reads address 5 on the next cycle → rd_valid=0001 with rd_data=0xDEADBEEF.
- Same-cycle write of 0x1234 to address 7 (old content 0xAAAA) and read of address 7 → rd_data=0xAAAA without the macro, 0x1234 with XIL_DP_ARB_BYPASS_EN.
- Requester 1 writes and reads in the same cycle while requester 3 also writes → wr_gnt and rd_gnt are each one-hot and correct; the write pointer advances past the winner only.
- Issue reads on 2 consecutive cycles, then assert rstb for 1 cycle → no rd_valid for the dropped reads; pointers restart at 0.
- With RD_LATENCY=2, a single read → ram_regceb high exactly 1 cycle after ram_enb, and rd_valid high 1 cycle after that.

Source files
------------

// File: rtl/xil_dp_arb_pkg.sv
// xil_dp_arb_pkg: shared helpers and types for the dual-port BRAM arbiter.
// The tag struct is sized for the largest supported configuration
// (8 requesters, data up to TAG_MAX_W bits). Smaller builds zero-fill the
// unused upper bits, and synthesis removes them as constants.
package xil_dp_arb_pkg;

  localparam int TAG_MAX_REQ = 8;
  localparam int TAG_MAX_W   = 128;

  // Ceiling log2. Returns 0 for values of 0 and 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Address width for a RAM of the given depth. Always at least 1 bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? clog2(depth) : 1;
  endfunction

  // One entry of the read-return pipeline.
  typedef struct packed {
    logic                   valid;
    logic [TAG_MAX_REQ-1:0] id;
    logic                   byp;
    logic [TAG_MAX_W-1:0]   byp_data;
  } rd_tag_t;

endpackage

// File: rtl/xil_dp_arbiter_if.sv
// xil_dp_arbiter_if: requester-side bus plus BRAM wrapper port bundle.
// The master view belongs to the environment (the requesters and the RAM
// wrapper). The slave view belongs to the arbiter.
interface xil_dp_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int RAM_WIDTH = 32,
  parameter int ADDR_W    = 11
);
  logic [NUM_REQ-1:0]           wr_req;
  logic [NUM_REQ*ADDR_W-1:0]    wr_addr;
  logic [NUM_REQ*RAM_WIDTH-1:0] wr_data;
  logic [NUM_REQ-1:0]           wr_gnt;
  logic [NUM_REQ-1:0]           rd_req;
  logic [NUM_REQ*ADDR_W-1:0]    rd_addr;
  logic [NUM_REQ-1:0]           rd_gnt;
  logic [NUM_REQ-1:0]           rd_valid;
  logic [RAM_WIDTH-1:0]         rd_data;
  logic [ADDR_W-1:0]            ram_addra;
  logic [RAM_WIDTH-1:0]         ram_dina;
  logic                         ram_wea;
  logic [ADDR_W-1:0]            ram_addrb;
  logic                         ram_enb;
  logic                         ram_regceb;
  logic                         ram_rstb;
  logic [RAM_WIDTH-1:0]         ram_doutb;

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_doutb,
    input  wr_gnt, rd_gnt, rd_valid, rd_data,
    input  ram_addra, ram_dina, ram_wea, ram_addrb, ram_enb, ram_regceb, ram_rstb
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_doutb,
    output wr_gnt, rd_gnt, rd_valid, rd_data,
    output ram_addra, ram_dina, ram_wea, ram_addrb, ram_enb, ram_regceb, ram_rstb
  );
endinterface

// File: rtl/xil_rr_arbiter.sv
// xil_rr_arbiter: combinational round-robin pick with a registered pointer.
// The winner is the lowest index at or after the pointer, with wrap-around.
// After a grant, the pointer moves to the slot just past the winner.
module xil_rr_arbiter
  import xil_dp_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clka,
  input  logic         rstb,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PTR_W = clog2(N);

  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W-1:0] cand_s;
  logic [PTR_W-1:0] win_idx_s;
  logic             win_s;
  logic             take_s;

  // Scan from the pointer and take the first active request; grant nothing in reset.
  always_comb begin
    gnt       = '0;
    win_s     = 1'b0;
    win_idx_s = '0;
    cand_s    = '0;
    take_s    = 1'b0;
    if (rstb) begin
      gnt = '0;
    end else begin
      for (int off = 0; off < N; off++) begin
        cand_s    = PTR_W'((int'(ptr_r) + off) % N);
        take_s    = !win_s && req[cand_s];
        win_idx_s = take_s ? cand_s : win_idx_s;
        win_s     = win_s | take_s;
      end
      gnt[win_idx_s] = win_s;
    end
  end

  // Move the priority pointer past the winner; hold it when nothing is granted.
  always_ff @(posedge clka) begin
    if (rstb) begin
      ptr_r <= '0;
    end else if (win_s) begin
      ptr_r <= (win_idx_s == PTR_W'(N - 1)) ? '0 : win_idx_s + PTR_W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/xil_dp_arbiter.sv
// xil_dp_arbiter: shares one simple dual-port BRAM among NUM_REQ requesters.
// The write port and the read port each have their own round-robin arbiter.
// Returned read words are tagged with their owner through a pipeline that
// matches the RAM read latency (RD_LATENCY = 1 or 2).
// Optional feature: define XIL_DP_ARB_BYPASS_EN to forward same-cycle,
// same-address write data to the colliding read. Without it, the read sees
// the old contents (read-first).
module xil_dp_arbiter
  import xil_dp_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int RAM_WIDTH  = 32,
  parameter int RAM_DEPTH  = 2048,
  parameter int RD_LATENCY = 1
) (
  input  logic             clka,
  input  logic             rstb,
  xil_dp_arbiter_if.slave  bus
);

  localparam int ADDR_W = addr_w(RAM_DEPTH);

  logic [NUM_REQ-1:0]   wr_gnt_s;
  logic [NUM_REQ-1:0]   rd_gnt_s;
  logic [ADDR_W-1:0]    addra_s;
  logic [RAM_WIDTH-1:0] dina_s;
  logic [ADDR_W-1:0]    addrb_s;
  logic                 collide_s;
  rd_tag_t              tag_in_s;
  rd_tag_t              tag_r [RD_LATENCY];
  rd_tag_t              tag_last_s;
  logic                 tag_unused_s;

  xil_rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
    .clka (clka),
    .rstb (rstb),
    .req  (bus.wr_req),
    .gnt  (wr_gnt_s)
  );

  xil_rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
    .clka (clka),
    .rstb (rstb),
    .req  (bus.rd_req),
    .gnt  (rd_gnt_s)
  );

  // Steer the granted requester's slices onto the RAM ports with one-hot AND-OR muxes.
  always_comb begin
    addra_s = '0;
    dina_s  = '0;
    addrb_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      addra_s = addra_s | ({ADDR_W{wr_gnt_s[i]}}    & bus.wr_addr[i*ADDR_W +: ADDR_W]);
      dina_s  = dina_s  | ({RAM_WIDTH{wr_gnt_s[i]}} & bus.wr_data[i*RAM_WIDTH +: RAM_WIDTH]);
      addrb_s = addrb_s | ({ADDR_W{rd_gnt_s[i]}}    & bus.rd_addr[i*ADDR_W +: ADDR_W]);
    end
  end

  assign bus.wr_gnt    = wr_gnt_s;
  assign bus.rd_gnt    = rd_gnt_s;
  assign bus.ram_wea   = |wr_gnt_s;
  assign bus.ram_addra = addra_s;
  assign bus.ram_dina  = dina_s;
  assign bus.ram_enb   = |rd_gnt_s;
  assign bus.ram_addrb = addrb_s;
  assign bus.ram_rstb  = rstb;

`ifdef XIL_DP_ARB_BYPASS_EN
  assign collide_s = (|wr_gnt_s) & (|rd_gnt_s) & (addra_s == addrb_s);
`else
  assign collide_s = 1'b0;
`endif

  // Build the stage-0 tag from this cycle's read grant.
  always_comb begin
    tag_in_s                   = '0;
    tag_in_s.valid             = |rd_gnt_s;
    tag_in_s.id[NUM_REQ-1:0]   = rd_gnt_s;
    tag_in_s.byp               = collide_s;
`ifdef XIL_DP_ARB_BYPASS_EN
    tag_in_s.byp_data[RAM_WIDTH-1:0] = dina_s;
`endif
  end

  // Move tags down the pipeline; reset drops every read that is in flight.
  always_ff @(posedge clka) begin
    if (rstb) begin
      for (int s = 0; s < RD_LATENCY; s++) begin
        tag_r[s] <= '0;
      end
    end else begin
      tag_r[0] <= tag_in_s;
      for (int s = 1; s < RD_LATENCY; s++) begin
        tag_r[s] <= tag_r[s-1];
      end
    end
  end

  assign tag_last_s   = tag_r[RD_LATENCY-1];
  assign tag_unused_s = ^tag_last_s;

  // Mark the returned word with its owner's id; idle cycles return all zeros.
  always_comb begin
    bus.rd_valid = '0;
    bus.rd_data  = '0;
    if (tag_last_s.valid) begin
      bus.rd_valid = tag_last_s.id[NUM_REQ-1:0];
      if (tag_last_s.byp) begin
        bus.rd_data = tag_last_s.byp_data[RAM_WIDTH-1:0];
      end else begin
        bus.rd_data = bus.ram_doutb;
      end
    end else begin
      bus.rd_valid = '0;
      bus.rd_data  = '0;
    end
  end

  // The RAM output register only loads when a read is in the middle stage.
  generate
    if (RD_LATENCY >= 2) begin : g_regce
      assign bus.ram_regceb = tag_r[RD_LATENCY-2].valid;
    end else begin : g_no_regce
      assign bus.ram_regceb = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_xil_dp_arbiter.sv
// tb_xil_dp_arbiter: two arbiters (RD_LATENCY 1 and 2) share one stimulus
// stream. A behavioural BRAM model sits behind each of them. A reference
// model predicts grants, RAM port values and returned read words. Read
// returns go into per-instance queues, and a separate monitor pops and
// compares them.
module tb_xil_dp_arbiter;
  import xil_dp_arb_pkg::*;

  localparam int N     = 4;
  localparam int W     = 32;
  localparam int DEPTH = 2048;
  localparam int AW    = addr_w(DEPTH);

  logic clka = 1'b0;
  logic rstb = 1'b1;
  always #5 clka = ~clka;

  logic [N-1:0]    wr_req_v  = '0;
  logic [N-1:0]    rd_req_v  = '0;
  logic [N*AW-1:0] wr_addr_v = '0;
  logic [N*AW-1:0] rd_addr_v = '0;
  logic [N*W-1:0]  wr_data_v = '0;

  xil_dp_arbiter_if #(.NUM_REQ(N), .RAM_WIDTH(W), .ADDR_W(AW)) if1 ();
  xil_dp_arbiter_if #(.NUM_REQ(N), .RAM_WIDTH(W), .ADDR_W(AW)) if2 ();

  assign if1.wr_req = wr_req_v;  assign if2.wr_req = wr_req_v;
  assign if1.rd_req = rd_req_v;  assign if2.rd_req = rd_req_v;
  assign if1.wr_addr = wr_addr_v; assign if2.wr_addr = wr_addr_v;
  assign if1.rd_addr = rd_addr_v; assign if2.rd_addr = rd_addr_v;
  assign if1.wr_data = wr_data_v; assign if2.wr_data = wr_data_v;

  xil_dp_arbiter #(.NUM_REQ(N), .RAM_WIDTH(W), .RAM_DEPTH(DEPTH), .RD_LATENCY(1)) dut1 (
    .clka(clka), .rstb(rstb), .bus(if1));
  xil_dp_arbiter #(.NUM_REQ(N), .RAM_WIDTH(W), .RAM_DEPTH(DEPTH), .RD_LATENCY(2)) dut2 (
    .clka(clka), .rstb(rstb), .bus(if2));

  // Behavioural BRAMs: read-first arrays. Lat-1 has an output latch; lat-2 adds a register.
  logic [W-1:0] mem1 [DEPTH] = '{default: '0};
  logic [W-1:0] mem2 [DEPTH] = '{default: '0};
  logic [W-1:0] q1 = '0, q2a = '0, q2b = '0;
  always @(posedge clka) begin
    if (if1.ram_rstb) q1 <= '0; else if (if1.ram_enb) q1 <= mem1[if1.ram_addrb];
    if (if1.ram_wea) mem1[if1.ram_addra] <= if1.ram_dina;
    if (if2.ram_enb) q2a <= mem2[if2.ram_addrb];
    if (if2.ram_rstb) q2b <= '0; else if (if2.ram_regceb) q2b <= q2a;
    if (if2.ram_wea) mem2[if2.ram_addra] <= if2.ram_dina;
  end
  assign if1.ram_doutb = q1;
  assign if2.ram_doutb = q2b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model state
  typedef struct { int due; logic [N-1:0] id; logic [W-1:0] data; } exp_t;
  exp_t q [2][$];
  logic [W-1:0] model_mem [DEPTH] = '{default: '0};
  int wptr = 0, rptr = 0;
  logic prev_rd = 1'b0;
  int m_wi, m_ri;
  logic [N-1:0] m_ew, m_er;
  logic [AW-1:0] m_wa, m_ra;
  logic [W-1:0] m_wd, m_rd;

  // Round-robin rule: first active index at or after ptr, wrapping around.
  function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      int idx = (ptr + k) % N;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic chk_ports(input string nm, input logic [N-1:0] wg, input logic [N-1:0] rg,
                           input logic wea, input logic [AW-1:0] aa, input logic [W-1:0] da,
                           input logic enb, input logic [AW-1:0] ab, input logic regce,
                           input logic rrst, input logic exp_regce);
    chk({nm, " wr_gnt"}, 64'(wg), 64'(m_ew));
    chk({nm, " rd_gnt"}, 64'(rg), 64'(m_er));
    chk({nm, " ram_wea"}, 64'(wea), 64'(m_wi >= 0));
    chk({nm, " ram_addra"}, 64'(aa), 64'(m_wa));
    chk({nm, " ram_dina"}, 64'(da), 64'(m_wd));
    chk({nm, " ram_enb"}, 64'(enb), 64'(m_ri >= 0));
    chk({nm, " ram_addrb"}, 64'(ab), 64'(m_ra));
    chk({nm, " ram_regceb"}, 64'(regce), 64'(exp_regce));
    chk({nm, " ram_rstb"}, 64'(rrst), 64'(rstb));
  endtask

  // Model: predict this cycle's grants and port values, then queue the read returns.
  always @(negedge clka) begin
    if (rstb) begin m_wi = -1; m_ri = -1; end
    else begin m_wi = rr_pick(wr_req_v, wptr); m_ri = rr_pick(rd_req_v, rptr); end
    m_ew = '0; m_er = '0; m_wa = '0; m_wd = '0; m_ra = '0;
    if (m_wi >= 0) begin
      m_ew[m_wi] = 1'b1; m_wa = wr_addr_v[m_wi*AW +: AW]; m_wd = wr_data_v[m_wi*W +: W];
    end
    if (m_ri >= 0) begin
      m_er[m_ri] = 1'b1; m_ra = rd_addr_v[m_ri*AW +: AW];
    end
    chk_ports("lat1", if1.wr_gnt, if1.rd_gnt, if1.ram_wea, if1.ram_addra, if1.ram_dina,
              if1.ram_enb, if1.ram_addrb, if1.ram_regceb, if1.ram_rstb, 1'b0);
    chk_ports("lat2", if2.wr_gnt, if2.rd_gnt, if2.ram_wea, if2.ram_addra, if2.ram_dina,
              if2.ram_enb, if2.ram_addrb, if2.ram_regceb, if2.ram_rstb, prev_rd);
    if (m_ri >= 0) begin
      m_rd = model_mem[m_ra];
`ifdef XIL_DP_ARB_BYPASS_EN
      if (m_wi >= 0 && m_wa == m_ra) m_rd = m_wd;
`endif
      for (int k = 0; k < 2; k++) q[k].push_back('{cyc + 1 + k, m_er, m_rd});
    end
    if (m_wi >= 0) model_mem[m_wa] = m_wd;
    if (rstb) begin
      wptr = 0; rptr = 0;
      for (int k = 0; k < 2; k++)
        while (q[k].size() > 0 && q[k][$].due > cyc) void'(q[k].pop_back());
    end else begin
      if (m_wi >= 0) wptr = (m_wi + 1) % N;
      if (m_ri >= 0) rptr = (m_ri + 1) % N;
    end
    prev_rd = (m_ri >= 0);
  end

  // Monitor: compare each instance's returned word with the queued expectation.
  always @(negedge clka) begin
    for (int k = 0; k < 2; k++) begin
      logic [N-1:0] av;
      logic [W-1:0] ad;
      string nm;
      av = (k == 0) ? if1.rd_valid : if2.rd_valid;
      ad = (k == 0) ? if1.rd_data : if2.rd_data;
      nm = (k == 0) ? "lat1" : "lat2";
      while (q[k].size() > 0 && q[k][0].due < cyc) begin
        checks++; errors++;
        $display("FAIL %s missed return cycle %0d: due %0d never compared", nm, cyc, q[k][0].due);
        void'(q[k].pop_front());
      end
      if (q[k].size() > 0 && q[k][0].due == cyc) begin
        chk({nm, " rd_valid"}, 64'(av), 64'(q[k][0].id));
        chk({nm, " rd_data"}, 64'(ad), 64'(q[k][0].data));
        void'(q[k].pop_front());
      end else begin
        chk({nm, " rd_valid idle"}, 64'(av), 64'd0);
        chk({nm, " rd_data idle"}, 64'(ad), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic idle_all();
    wr_req_v = '0;
    rd_req_v = '0;
  endtask

  task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [W-1:0] d);
    wr_req_v[i] = 1'b1; wr_addr_v[i*AW +: AW] = a; wr_data_v[i*W +: W] = d;
  endtask

  task automatic set_rd(input int i, input logic [AW-1:0] a);
    rd_req_v[i] = 1'b1; rd_addr_v[i*AW +: AW] = a;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] gw, gr;
    // All four requesters read continuously from reset.
    rstb = 1'b1;
    rd_req_v = '1;
    for (int i = 0; i < N; i++) rd_addr_v[i*AW +: AW] = AW'(i);
    repeat (3) tick();
    rstb = 1'b0;
    repeat (6) tick();
    idle_all(); repeat (3) tick();
    // Write then read-back on the next cycle.
    set_wr(2, AW'(5), 32'hDEADBEEF); tick();
    idle_all(); set_rd(0, AW'(5)); tick();
    idle_all(); repeat (3) tick();
    // Same-cycle write/read collision on address 7.
    set_wr(0, AW'(7), 32'h0000AAAA); tick();
    idle_all(); set_wr(0, AW'(7), 32'h00001234); set_rd(1, AW'(7)); tick();
    idle_all(); repeat (3) tick();
    // Requester 1 writes and reads while requester 3 also writes.
    set_wr(1, AW'(9), 32'h11111111); set_wr(3, AW'(10), 32'h33333333); set_rd(1, AW'(9)); tick();
    rd_req_v = '0; tick();
    idle_all(); repeat (3) tick();
    // Two reads back to back, then a one-cycle reset drops what is in flight.
    set_rd(0, AW'(5)); tick();
    idle_all(); set_rd(1, AW'(7)); tick();
    idle_all(); rstb = 1'b1; tick();
    rstb = 1'b0; rd_req_v = '1; wr_req_v = '1; tick();
    idle_all(); repeat (3) tick();
    // Randomised traffic: requests are held until granted, sometimes withdrawn, with rare resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clka);
      gw = if1.wr_gnt;
      gr = if1.rd_gnt;
      @(posedge clka);
      #1;
      for (int i = 0; i < N; i++) begin
        if (gw[i] || !wr_req_v[i]) begin
          wr_req_v[i] = ($urandom_range(0, 99) < 50);
          wr_addr_v[i*AW +: AW] = AW'($urandom_range(0, 15));
          wr_data_v[i*W +: W] = W'($urandom);
        end else if ($urandom_range(0, 99) < 5) begin
          wr_req_v[i] = 1'b0;
        end
        if (gr[i] || !rd_req_v[i]) begin
          rd_req_v[i] = ($urandom_range(0, 99) < 50);
          rd_addr_v[i*AW +: AW] = AW'($urandom_range(0, 15));
        end else if ($urandom_range(0, 99) < 5) begin
          rd_req_v[i] = 1'b0;
        end
      end
      rstb = ($urandom_range(0, 999) < 5);
    end
    rstb = 1'b0;
    idle_all();
    repeat (5) tick();
    chk("pending returns drained", 64'(q[0].size() + q[1].size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
